// File: rtl/jedro_1_lsu_pkg.sv
// Shared definitions for the jedro_1 load-store unit: access sizes, FSM
// state encoding and small address helpers used by the top and the aligner.
package jedro_1_lsu_pkg;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10,
        LSU_WB   = 2'b11
    } lsu_state_e;

    // Byte offset actually used for lane selection: bits below the access
    // size are ignored, so a half uses a[1] only and a word always lane 0.
    function automatic logic [1:0] lsu_eff_offset(input logic [1:0] size,
                                                  input logic [1:0] a);
        logic [1:0] off;
        case (size)
            LSU_SIZE_BYTE: off = a;
            LSU_SIZE_HALF: off = {a[1], 1'b0};
            default:       off = 2'b00;
        endcase
        return off;
    endfunction

    // True when the address is not naturally aligned for the access size.
    function automatic logic lsu_is_misaligned(input logic [1:0] size,
                                               input logic [1:0] a);
        logic mis;
        case (size)
            LSU_SIZE_BYTE: mis = 1'b0;
            LSU_SIZE_HALF: mis = a[0];
            default:       mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/jedro_1_lsu_align.sv
// Combinational data aligner for the LSU.
// Store side: byte enables and lane-replicated write data.
// Load side: lane select of the response word and sign/zero extension.
module jedro_1_lsu_align
    import jedro_1_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            st_size,
    input  logic [1:0]            st_offset,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [3:0]            st_be,
    output logic [DATA_WIDTH-1:0] st_wdata_rep,
    input  logic [1:0]            ld_size,
    input  logic [1:0]            ld_offset,
    input  logic                  ld_unsigned,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    logic [DATA_WIDTH-1:0] ld_shifted;

    // Byte enables: a contiguous mask shifted to the (already masked) offset.
    always_comb begin
        case (st_size)
            LSU_SIZE_BYTE: st_be = 4'b0001 << st_offset;
            LSU_SIZE_HALF: st_be = 4'b0011 << st_offset;
            default:       st_be = 4'b1111;
        endcase
    end

    // Replicate the low byte/half into every lane so any byte enable pattern
    // picks up the right bits without a data shifter.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (st_size)
                    LSU_SIZE_BYTE: st_wdata_rep[8*gi +: 8] = st_wdata[7:0];
                    LSU_SIZE_HALF: st_wdata_rep[8*gi +: 8] = st_wdata[8*(gi%2) +: 8];
                    default:       st_wdata_rep[8*gi +: 8] = st_wdata[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    assign ld_shifted = ld_rdata >> {ld_offset, 3'b000};

    // Extend the selected lane to register width.
    always_comb begin
        case (ld_size)
            LSU_SIZE_BYTE: ld_data = ld_unsigned ? {24'b0, ld_shifted[7:0]}
                                                 : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LSU_SIZE_HALF: ld_data = ld_unsigned ? {16'b0, ld_shifted[15:0]}
                                                 : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            default:       ld_data = ld_shifted;
        endcase
    end

endmodule

// File: rtl/jedro_1_lsu.sv
// jedro_1 load-store unit: one memory access at a time over a req/gnt/rvalid
// bus, load data aligned/extended and written back to the register file.
// Optional: JEDRO_1_LSU_MISALIGN_CHECK_EN rejects misaligned half/word
// accesses with a one-cycle misaligned_o pulse and no bus request.
module jedro_1_lsu
    import jedro_1_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ctrl_valid_i,
    output logic                      ctrl_ready_o,
    input  logic                      ctrl_we_i,
    input  logic [1:0]                ctrl_size_i,
    input  logic                      ctrl_unsigned_i,
    input  logic [REG_ADDR_WIDTH-1:0] ctrl_regdest_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      data_req_o,
    input  logic                      data_gnt_i,
    output logic [ADDR_WIDTH-1:0]     data_addr_o,
    output logic                      data_we_o,
    output logic [3:0]                data_be_o,
    output logic [DATA_WIDTH-1:0]     data_wdata_o,
    input  logic                      data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     data_rdata_i,
    output logic                      rf_we_o,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      misaligned_o
);

    lsu_state_e                state_reg;
    logic [ADDR_WIDTH-1:0]     addr_reg;
    logic                      we_reg;
    logic [3:0]                be_reg;
    logic [DATA_WIDTH-1:0]     wdata_reg;
    logic [1:0]                size_reg;
    logic [1:0]                offset_reg;
    logic                      unsigned_reg;
    logic [REG_ADDR_WIDTH-1:0] regdest_reg;
    logic [DATA_WIDTH-1:0]     rf_wdata_reg;

    logic [1:0]                acc_offset;
    logic [3:0]                acc_be;
    logic [DATA_WIDTH-1:0]     acc_wdata;
    logic [DATA_WIDTH-1:0]     ld_data;
    logic                      resp_fire;
    logic                      accept;
    logic                      acc_misaligned;

    assign acc_offset = lsu_eff_offset(ctrl_size_i, addr_i[1:0]);
    assign accept     = ctrl_valid_i && (state_reg == LSU_IDLE);

`ifdef JEDRO_1_LSU_MISALIGN_CHECK_EN
    logic misaligned_reg;
    assign acc_misaligned = lsu_is_misaligned(ctrl_size_i, addr_i[1:0]);
    assign misaligned_o   = misaligned_reg;

    // One-cycle flag in the cycle after a misaligned op is accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misaligned_reg <= 1'b0;
        end else begin
            misaligned_reg <= accept && acc_misaligned;
        end
    end
`else
    assign acc_misaligned = 1'b0;
    assign misaligned_o   = 1'b0;
`endif

    jedro_1_lsu_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .st_size     (ctrl_size_i),
        .st_offset   (acc_offset),
        .st_wdata    (wdata_i),
        .st_be       (acc_be),
        .st_wdata_rep(acc_wdata),
        .ld_size     (size_reg),
        .ld_offset   (offset_reg),
        .ld_unsigned (unsigned_reg),
        .ld_rdata    (data_rdata_i),
        .ld_data     (ld_data)
    );

    // A response counts in RESP, or in REQ when it arrives together with gnt.
    assign resp_fire = data_rvalid_i &&
                       ((state_reg == LSU_RESP) ||
                        ((state_reg == LSU_REQ) && data_gnt_i));

    // Main access FSM and the registered bus/write-back fields.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= LSU_IDLE;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            be_reg       <= 4'b0000;
            wdata_reg    <= '0;
            size_reg     <= LSU_SIZE_BYTE;
            offset_reg   <= 2'b00;
            unsigned_reg <= 1'b0;
            regdest_reg  <= '0;
            rf_wdata_reg <= '0;
        end else begin
            case (state_reg)
                LSU_IDLE: begin
                    if (accept) begin
                        addr_reg     <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        we_reg       <= ctrl_we_i;
                        be_reg       <= acc_be;
                        wdata_reg    <= acc_wdata;
                        size_reg     <= ctrl_size_i;
                        offset_reg   <= acc_offset;
                        unsigned_reg <= ctrl_unsigned_i;
                        regdest_reg  <= ctrl_regdest_i;
                        state_reg    <= acc_misaligned ? LSU_IDLE : LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (data_gnt_i) begin
                        if (resp_fire) begin
                            state_reg <= we_reg ? LSU_IDLE : LSU_WB;
                            if (!we_reg) begin
                                rf_wdata_reg <= ld_data;
                            end
                        end else begin
                            state_reg <= LSU_RESP;
                        end
                    end
                end
                LSU_RESP: begin
                    if (resp_fire) begin
                        state_reg <= we_reg ? LSU_IDLE : LSU_WB;
                        if (!we_reg) begin
                            rf_wdata_reg <= ld_data;
                        end
                    end
                end
                LSU_WB: begin
                    state_reg <= LSU_IDLE;
                end
                default: begin
                    state_reg <= LSU_IDLE;
                end
            endcase
        end
    end

    assign ctrl_ready_o = (state_reg == LSU_IDLE);
    // Reset removes the request in the same cycle it is raised.
    assign data_req_o   = (state_reg == LSU_REQ) && !rst_i;
    assign data_addr_o  = addr_reg;
    assign data_we_o    = we_reg;
    assign data_be_o    = be_reg;
    assign data_wdata_o = wdata_reg;
    // Writes to x0 are dropped.
    assign rf_we_o      = (state_reg == LSU_WB) && (regdest_reg != '0);
    assign rf_addr_o    = regdest_reg;
    assign rf_wdata_o   = rf_wdata_reg;

endmodule
